uart_alu: RTL and testbench

- UART-attached arithmetic co-processor: receives command packets on a serial RX line, executes echo/add/multiply/divide, returns results on a serial TX line.
- Top-level block of the FPGA design; the DV runner drives it via rxd_i and decodes txd_o.
- Serial framing is 8N1, LSB first, idle high.

---
 rtl/uart_alu_pkg.sv | 32 +++
 rtl/alu_div32.sv | 114 +++++++++++
 rtl/uart_rx.sv | 98 +++++++++
 rtl/uart_tx.sv | 95 +++++++++
 rtl/uart_alu.sv | 210 +++++++++++++++++++++
 tb/tb_uart_alu.sv | 275 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared types and constants for the UART arithmetic co-processor.
//   opcode_e     - command byte values carried in byte0 of a packet
//   state_e      - packet-level FSM states of uart_alu
//   HEADER_BYTES - opcode + reserved + 16-bit LEN
package uart_alu_pkg;

  localparam int unsigned HEADER_BYTES = 4;

  typedef enum logic [7:0] {
    OP_ECHO  = 8'hEC,
    OP_ADD32 = 8'hA0,
    OP_MUL32 = 8'hA1,
    OP_DIV32 = 8'hA2
  } opcode_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_COMPUTE,
    ST_RESPOND,
    ST_DRAIN
  } state_e;

  function automatic logic is_alu_op(input logic [7:0] op);
    return (op == OP_ADD32) || (op == OP_MUL32) || (op == OP_DIV32);
  endfunction

endpackage

// File: rtl/alu_div32.sv
// alu_div32: sequential signed restoring divider, truncating toward zero.
//   start_i                - sample operands and begin (ignored while busy)
//   dividend_i, divisor_i  - signed 32-bit operands
//   busy_o                 - iteration in progress
//   done_o                 - one-cycle pulse, results valid from then on
//   quotient_o             - divisor 0 gives all ones; MIN/-1 gives MIN
//   remainder_o            - sign follows dividend; divisor 0 gives dividend
module alu_div32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] qres_q, qres_d;
  logic [31:0] rres_q, rres_d;

  logic [32:0] r_sh, diff;
  logic [31:0] rem_nx, quo_nx;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = qres_q;
  assign remainder_o = rres_q;

  always_comb begin
    // One restoring step on magnitudes: shift in next dividend bit, try subtract.
    r_sh   = {rem_q, quo_q[31]};
    diff   = r_sh - {1'b0, dvs_q};
    rem_nx = diff[32] ? r_sh[31:0] : diff[31:0];
    quo_nx = {quo_q[30:0], ~diff[32]};

    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    qres_d = qres_q;
    rres_d = rres_q;

    if (busy_q) begin
      rem_d = rem_nx;
      quo_d = quo_nx;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        qres_d = qneg_q ? -quo_nx : quo_nx;
        rres_d = rneg_q ? -rem_nx : rem_nx;
      end
    end else if (start_i) begin
      qneg_d = dividend_i[31] ^ divisor_i[31];
      rneg_d = dividend_i[31];
      dvs_d  = divisor_i[31] ? -divisor_i : divisor_i;
      quo_d  = dividend_i[31] ? -dividend_i : dividend_i;
      rem_d  = '0;
      cnt_d  = '0;
      if (divisor_i == '0) begin
        qres_d = '1;
        rres_d = dividend_i;
        done_d = 1'b1;
      end else if ((dividend_i == 32'h8000_0000) && (divisor_i == '1)) begin
        qres_d = 32'h8000_0000;
        rres_d = '0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dvs_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      qres_q <= '0;
      rres_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      qres_q <= qres_d;
      rres_q <= rres_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, LSB first, idle high.
//   clk_i/rst_i - clock, async active-high reset
//   rxd_i       - asynchronous serial input (double-flop synchronised here)
//   valid_o     - one-cycle pulse when data_o holds a correctly framed byte
//   data_o      - received byte
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic       valid_o,
  output logic [7:0] data_o
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync1_q, sync2_q, prev_q;
  logic          valid_q, valid_d;

  assign valid_o = valid_q;
  assign data_o  = shift_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    unique case (state_q)
      // A start needs a real high-to-low edge, so a line left low after a
      // framing error is not mistaken for a new start bit.
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          valid_d = sync2_q;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter, LSB first, idle high.
//   clk_i/rst_i - clock, async active-high reset
//   valid_i     - byte offered on data_i
//   data_i      - byte to send
//   ready_o     - byte accepted when valid_i && ready_o
//   txd_o       - registered serial output
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       txd_o
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  assign txd_o = txd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    // Accepting in the final stop-bit cycle keeps back-to-back bytes at
    // exactly one stop bit.
    ready_o = (state_q == TX_IDLE) || ((state_q == TX_STOP) && (cnt_q == LAST));
    unique case (state_q)
      TX_IDLE: ;
      TX_START: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    if (ready_o && valid_i) begin
      shift_d = data_i;
      cnt_d   = '0;
      state_d = TX_START;
    end
    txd_d = (state_d == TX_START) ? 1'b0 :
            (state_d == TX_DATA)  ? shift_d[0] : 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/uart_alu.sv
// uart_alu: UART-attached arithmetic co-processor (echo/add/mul/div).
//   clk_i - system clock
//   rst_i - asynchronous active-high reset
//   rxd_i - serial command input, 8N1, idle high
//   txd_o - serial response output, 8N1, idle high
module uart_alu #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD_RATE   = 115200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rxd_i,
  output logic txd_o
);
  import uart_alu_pkg::*;

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        div_start, div_busy, div_done;
  logic [31:0] div_quo, div_rem;

  state_e      state_q, state_d;
  logic [7:0]  opc_q, opc_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] remain_q, remain_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        first_q, first_d;
  logic [23:0] op_q, op_d;
  logic [31:0] acc_q, acc_d;
  logic [63:0] res_q, res_d;
  logic [3:0]  resp_left_q, resp_left_d;

  logic [15:0] len_w, pay_w;
  logic [31:0] opnd_full;
  logic        bad_pkt;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rxd_i   (rxd_i),
    .valid_o (rx_valid),
    .data_o  (rx_data)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (tx_valid),
    .data_i  (tx_data),
    .ready_o (tx_ready),
    .txd_o   (txd_o)
  );

  alu_div32 u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (div_start),
    .dividend_i  (acc_q),
    .divisor_i   (opnd_full),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    len_lo_d    = len_lo_q;
    remain_d    = remain_q;
    byte_idx_d  = byte_idx_q;
    first_d     = first_q;
    op_d        = op_q;
    acc_d       = acc_q;
    res_d       = res_q;
    resp_left_d = resp_left_q;
    tx_valid    = 1'b0;
    tx_data     = res_q[7:0];
    div_start   = 1'b0;
    len_w       = {rx_data, len_lo_q};
    pay_w       = len_w - 16'(HEADER_BYTES);
    opnd_full   = {rx_data, op_q};
    bad_pkt     = !(is_alu_op(opc_q) || (opc_q == OP_ECHO)) ||
                  (len_w < 16'(HEADER_BYTES)) ||
                  (is_alu_op(opc_q) && (pay_w[1:0] != 2'b00)) ||
                  ((opc_q == OP_DIV32) && (len_w != 16'd12));

    unique case (state_q)
      ST_IDLE: begin
        opc_d       = '0;
        remain_d    = '0;
        byte_idx_d  = '0;
        first_d     = 1'b1;
        acc_d       = '0;
        res_d       = '0;
        resp_left_d = '0;
        state_d     = ST_OPCODE;
      end
      ST_OPCODE: if (rx_valid) begin
        opc_d   = rx_data;
        state_d = ST_RSVD;
      end
      ST_RSVD: if (rx_valid) state_d = ST_LEN_LO;
      ST_LEN_LO: if (rx_valid) begin
        len_lo_d = rx_data;
        state_d  = ST_LEN_HI;
      end
      ST_LEN_HI: if (rx_valid) begin
        remain_d = (len_w < 16'(HEADER_BYTES)) ? '0 : pay_w;
        if (bad_pkt) begin
          state_d = (len_w <= 16'(HEADER_BYTES)) ? ST_IDLE : ST_DRAIN;
        end else if (pay_w == '0) begin
          if (opc_q == OP_ECHO) begin
            state_d = ST_IDLE;
          end else begin
            res_d       = '0;
            resp_left_d = 4'd4;
            state_d     = ST_RESPOND;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (opc_q == OP_ECHO) begin
          tx_valid = (resp_left_q != '0);
          if (tx_valid && tx_ready) resp_left_d = '0;
        end
        if (rx_valid) begin
          remain_d = remain_q - 1'b1;
          if (opc_q == OP_ECHO) begin
            // Same-cycle tx accept already latched the old byte; overwrite is safe.
            res_d[7:0]  = rx_data;
            resp_left_d = 4'd1;
            if (remain_q == 16'd1) state_d = ST_RESPOND;
          end else begin
            op_d       = opnd_full[31:8];
            byte_idx_d = byte_idx_q + 1'b1;
            if (byte_idx_q == 2'd3) begin
              first_d = 1'b0;
              if (first_q)                acc_d = opnd_full;
              else if (opc_q == OP_ADD32) acc_d = acc_q + opnd_full;
              else if (opc_q == OP_MUL32) acc_d = acc_q * opnd_full;
              if (remain_q == 16'd1) begin
                if (opc_q == OP_DIV32) begin
                  div_start = !div_busy;
                  state_d   = ST_COMPUTE;
                end else begin
                  res_d       = {32'h0, acc_d};
                  resp_left_d = 4'd4;
                  state_d     = ST_RESPOND;
                end
              end
            end
          end
        end
      end
      ST_COMPUTE: if (div_done && !div_busy) begin
        res_d       = {div_rem, div_quo};
        resp_left_d = 4'd8;
        state_d     = ST_RESPOND;
      end
      ST_RESPOND: begin
        tx_valid = (resp_left_q != '0);
        if (tx_valid && tx_ready) begin
          res_d       = res_q >> 8;
          resp_left_d = resp_left_q - 1'b1;
        end else if ((resp_left_q == '0) && tx_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: if (rx_valid) begin
        remain_d = remain_q - 1'b1;
        if (remain_q == 16'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      opc_q       <= '0;
      len_lo_q    <= '0;
      remain_q    <= '0;
      byte_idx_q  <= '0;
      first_q     <= 1'b1;
      op_q        <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      resp_left_q <= '0;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      len_lo_q    <= len_lo_d;
      remain_q    <= remain_d;
      byte_idx_q  <= byte_idx_d;
      first_q     <= first_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      resp_left_q <= resp_left_d;
    end
  end

endmodule

// File: tb/tb_uart_alu.sv
// tb_uart_alu: directed bench for uart_alu driving rxd_i and decoding txd_o.
module tb_uart_alu;

  localparam int unsigned CLK_HZ = 921600;
  localparam int unsigned BAUD   = 115200;
  localparam int unsigned CPB    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic txd;

  int tests = 0;
  int fails = 0;
  int frame_errs = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pkt[$];

  always #5 clk = ~clk;

  uart_alu #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rxd_i (rxd),
    .txd_o (txd)
  );

  // Serial monitor: decode txd bytes into got_q.
  initial begin : mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        repeat (CPB / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        if (txd !== 1'b1) frame_errs++;
        got_q.push_back(b);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
    rxd = 1'b1;
    if (!stop) tick(2 * CPB);
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i]);
    pkt.delete();
  endtask

  task automatic hdr(input logic [7:0] op, input logic [15:0] len);
    pkt.push_back(op);
    pkt.push_back(8'h00);
    pkt.push_back(len[7:0]);
    pkt.push_back(len[15:8]);
  endtask

  task automatic word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) pkt.push_back(w[8*i +: 8]);
  endtask

  task automatic exp_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic check_resp(input string name);
    int budget;
    int waited;
    budget = 300 + exp_q.size() * (12 * CPB);
    waited = 0;
    while (got_q.size() < exp_q.size() && waited < budget) begin
      tick(1);
      waited++;
    end
    tick(30 * CPB);
    tests++;
    assert (got_q.size() === exp_q.size()) else begin
      fails++;
      $error("FAIL %s count: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      assert (got_q[i] === exp_q[i]) else begin
        fails++;
        $error("FAIL %s[%0d]: got %02h, expected %02h", name, i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb, q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  initial begin : stim
    logic [31:0] a, b;
    logic [63:0] m;

    // Three back-to-back resets while idle.
    for (int k = 0; k < 3; k++) begin
      rst = 1'b1;
      tick(3);
      tests++;
      assert (txd === 1'b1) else begin
        fails++;
        $error("FAIL reset_txd: got %b, expected 1", txd);
      end
      rst = 1'b0;
      tick(1);
    end
    tick(40);
    tests++;
    assert (txd === 1'b1) else begin
      fails++;
      $error("FAIL idle_txd: got %b, expected 1", txd);
    end
    check_resp("reset_quiet");

    // ECHO LEN=8.
    hdr(8'hEC, 16'd8);
    pkt.push_back(8'h42); pkt.push_back(8'h69); pkt.push_back(8'h42); pkt.push_back(8'h69);
    exp_q.push_back(8'h42); exp_q.push_back(8'h69); exp_q.push_back(8'h42); exp_q.push_back(8'h69);
    send_pkt();
    check_resp("echo8");

    // MUL32 3 * -2 = -6.
    hdr(8'hA1, 16'd12); word(32'h0000_0003); word(32'hFFFF_FFFE);
    exp_word(32'hFFFF_FFFA);
    send_pkt();
    check_resp("mul_neg");

    // MUL32 wrap.
    hdr(8'hA1, 16'd12); word(32'h0001_0000); word(32'h0001_0000);
    exp_word(32'h0000_0000);
    send_pkt();
    check_resp("mul_wrap");

    // ADD32 three operands: 1 + 2 + (-1) = 2.
    hdr(8'hA0, 16'd16); word(32'h1); word(32'h2); word(32'hFFFF_FFFF);
    exp_word(32'h0000_0002);
    send_pkt();
    check_resp("add3");

    // ADD32 with no operands.
    hdr(8'hA0, 16'd4);
    exp_word(32'h0);
    send_pkt();
    check_resp("add_empty");

    // DIV32 100 / -7.
    hdr(8'hA2, 16'd12); word(32'd100); word(32'hFFFF_FFF9);
    exp_word(32'hFFFF_FFF2); exp_word(32'h0000_0002);
    send_pkt();
    check_resp("div_100_m7");

    // DIV32 -100 / 7: remainder takes the dividend's sign.
    hdr(8'hA2, 16'd12); word(32'hFFFF_FF9C); word(32'd7);
    exp_word(32'hFFFF_FFF2); exp_word(32'hFFFF_FFFE);
    send_pkt();
    check_resp("div_m100_7");

    // DIV32 by zero.
    hdr(8'hA2, 16'd12); word(32'h1234_5678); word(32'h0);
    exp_word(32'hFFFF_FFFF); exp_word(32'h1234_5678);
    send_pkt();
    check_resp("div_zero");

    // DIV32 overflow.
    hdr(8'hA2, 16'd12); word(32'h8000_0000); word(32'hFFFF_FFFF);
    exp_word(32'h8000_0000); exp_word(32'h0);
    send_pkt();
    check_resp("div_ovf");

    // Unknown opcode is drained silently; following ECHO works.
    hdr(8'h55, 16'd8); word(32'hDEAD_BEEF);
    send_pkt();
    check_resp("bad_opcode");
    hdr(8'hEC, 16'd6); pkt.push_back(8'h5A); pkt.push_back(8'hC3);
    exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    send_pkt();
    check_resp("echo_after_bad");

    // ADD32 payload not a multiple of 4.
    hdr(8'hA0, 16'd10); word(32'h1111_1111); pkt.push_back(8'h22); pkt.push_back(8'h33);
    send_pkt();
    check_resp("add_len10");

    // DIV32 with a single operand.
    hdr(8'hA2, 16'd8); word(32'd50);
    send_pkt();
    check_resp("div_len8");

    // LEN below header size, then a 1-byte ECHO.
    hdr(8'hEC, 16'd2);
    send_pkt();
    hdr(8'hEC, 16'd5); pkt.push_back(8'h7E);
    exp_q.push_back(8'h7E);
    send_pkt();
    check_resp("len_short_then_echo");

    // ECHO LEN=4 produces nothing.
    hdr(8'hEC, 16'd4);
    send_pkt();
    check_resp("echo_empty");

    // Framing error byte is discarded without leaving PAYLOAD.
    hdr(8'hEC, 16'd6);
    send_pkt();
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33);
    exp_q.push_back(8'h11); exp_q.push_back(8'h33);
    check_resp("echo_frame_err");

    // Random DIV32 against the reference model.
    for (int k = 0; k < 10; k++) begin
      a = $urandom;
      b = (k % 3 == 0) ? (32'($urandom_range(20)) - 32'd10) : $urandom;
      if (k == 4) a = a >> ($urandom_range(31));
      m = div_model(a, b);
      hdr(8'hA2, 16'd12); word(a); word(b);
      exp_word(m[31:0]); exp_word(m[63:32]);
      send_pkt();
      check_resp("fuzz_div");
    end

    // Random MUL32 against the reference model.
    for (int k = 0; k < 2; k++) begin
      a = $urandom;
      b = $urandom;
      hdr(8'hA1, 16'd12); word(a); word(b);
      exp_word(a * b);
      send_pkt();
      check_resp("fuzz_mul");
    end

    tests++;
    assert (frame_errs === 0) else begin
      fails++;
      $error("FAIL tx_stop_bits: got %0d bad stop bits, expected 0", frame_errs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
